// File: rtl/module_iir_biquad_lpf_pkg.sv
// Shared constants, DSP opmode codes and FSM state type for the biquad low-pass filter.
// Output saturation is optional and is enabled by defining IIR_BIQUAD_SATURATE_EN.
`ifndef DSP_NOP
`define DSP_NOP      8'h00
`endif
`ifndef DSP_XIN_MULT
`define DSP_XIN_MULT 8'h01
`endif
`ifndef DSP_ZIN_ZERO
`define DSP_ZIN_ZERO 8'h00
`endif
`ifndef DSP_ZIN_POUT
`define DSP_ZIN_POUT 8'h08
`endif

package module_iir_biquad_lpf_pkg;

    localparam int DSP_LATENCY = 3;
    localparam int N_TAPS      = 5;

    localparam logic [17:0] Q_ONE = 18'h10000;
    localparam logic [17:0] Q_MAX = 18'h1FFFF;
    localparam logic [17:0] Q_MIN = 18'h20000;

    // Index into {c0,c1,c2,c3,c4}; c0/c1 are the negated feedback terms.
    localparam int COEF_A1N = 0;
    localparam int COEF_A2N = 1;
    localparam int COEF_B0  = 2;
    localparam int COEF_B1  = 3;
    localparam int COEF_B2  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/module_iir_biquad_lpf_q2_16_sat.sv
// Converts a Q4.32 DSP accumulator to Q2.16, clamping to the Q2.16 range on overflow.
// Instantiated by the biquad top only when IIR_BIQUAD_SATURATE_EN is defined.
module module_q2_16_sat
    import module_iir_biquad_lpf_pkg::*;
(
    input  logic [47:0] i_p,
    output logic [17:0] o_q
);

    logic w_in_range;
    logic w_unused_frac;

    assign w_in_range    = (i_p[47:33] == {15{i_p[47]}});
    assign w_unused_frac = ^i_p[15:0];

    always_comb begin
        if (w_in_range) begin
            o_q = i_p[33:16];
        end else if (i_p[47]) begin
            o_q = Q_MIN;
        end else begin
            o_q = Q_MAX;
        end
    end

endmodule

// File: rtl/module_iir_biquad_lpf.sv
// Direct-form-I biquad on a shared DSP slice: five MAC issues per sample, then drain and output.
// Define IIR_BIQUAD_SATURATE_EN to clamp the output (and fed-back y1) instead of wrapping.
module module_iir_biquad_lpf
    import module_iir_biquad_lpf_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [89:0] coefs_flat,
    input  logic        coefs_valid,
    input  logic [17:0] sample_in,
    input  logic        sample_in_valid,
    output logic [17:0] sample_out,
    output logic        sample_out_valid,
    output logic        busy,
    output logic [91:0] dsp_ins_flat,
    input  logic [47:0] dsp_outs_flat
);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [17:0] r_x;
    logic [17:0] r_x1;
    logic [17:0] r_x2;
    logic [17:0] r_y1;
    logic [17:0] r_y2;
    logic [89:0] r_coefs_act;
    logic [89:0] r_coefs_pend;
    logic        r_pend_v;
    logic [17:0] r_sample_out;
    logic        r_out_valid;
    logic        r_busy;
    logic [91:0] r_dsp_ins;

    logic [17:0] w_coef [N_TAPS];
    logic [17:0] w_a;
    logic [17:0] w_b;
    logic [7:0]  w_opmode;
    logic [17:0] w_y;

    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_coef
            assign w_coef[gi] = r_coefs_act[(N_TAPS-1-gi)*18 +: 18];
        end
    endgenerate

    // Issue order: b0*x, b1*x1, b2*x2, a1n*y1, a2n*y2.
    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_cnt)
            3'd0: begin w_a = w_coef[COEF_B0];  w_b = r_x;  end
            3'd1: begin w_a = w_coef[COEF_B1];  w_b = r_x1; end
            3'd2: begin w_a = w_coef[COEF_B2];  w_b = r_x2; end
            3'd3: begin w_a = w_coef[COEF_A1N]; w_b = r_y1; end
            3'd4: begin w_a = w_coef[COEF_A2N]; w_b = r_y2; end
            default: ;
        endcase
    end

    assign w_opmode = (r_cnt == 3'd0) ? (`DSP_XIN_MULT | `DSP_ZIN_ZERO)
                                      : (`DSP_XIN_MULT | `DSP_ZIN_POUT);

`ifdef IIR_BIQUAD_SATURATE_EN
    module_q2_16_sat u_sat (
        .i_p (dsp_outs_flat),
        .o_q (w_y)
    );
`else
    logic w_unused_p;
    assign w_y        = dsp_outs_flat[33:16];
    assign w_unused_p = ^{dsp_outs_flat[47:34], dsp_outs_flat[15:0]};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_y1         <= '0;
            r_y2         <= '0;
            r_coefs_act  <= '0;
            r_coefs_pend <= '0;
            r_pend_v     <= 1'b0;
            r_sample_out <= '0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_dsp_ins    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_dsp_ins   <= '0;
            if (coefs_valid) begin
                r_coefs_pend <= coefs_flat;
                r_pend_v     <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    // A same-cycle coefs pulse stays pending for the following sample.
                    if (r_pend_v) begin
                        r_coefs_act <= r_coefs_pend;
                        if (!coefs_valid) begin
                            r_pend_v <= 1'b0;
                        end
                    end
                    if (sample_in_valid) begin
                        r_x     <= sample_in;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_dsp_ins <= {w_opmode, w_a, w_b, 48'd0};
                    if (r_cnt == 3'd4) begin
                        r_cnt   <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 3'(DSP_LATENCY - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_OUT: begin
                    r_sample_out <= w_y;
                    r_out_valid  <= 1'b1;
                    r_x2         <= r_x1;
                    r_x1         <= r_x;
                    r_y2         <= r_y1;
                    r_y1         <= w_y;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sample_out       = r_sample_out;
    assign sample_out_valid = r_out_valid;
    assign busy             = r_busy;
    assign dsp_ins_flat     = r_dsp_ins;

endmodule

// File: tb/tb_module_iir_biquad_lpf.sv
// Scoreboard bench for the biquad LPF with a behavioural 3-stage DSP48A1 model on the shared bus.
// Expected outputs follow IIR_BIQUAD_SATURATE_EN when it is defined for the build.
module tb_module_iir_biquad_lpf;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [89:0] coefs_flat = '0;
    logic        coefs_valid = 1'b0;
    logic [17:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;
    logic [17:0] sample_out;
    logic        sample_out_valid;
    logic        busy;
    logic [91:0] dsp_ins_flat;
    logic [47:0] dsp_outs_flat;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_out        = 0;
    int n_pushed     = 0;
    int cyc          = 0;

    logic [17:0] q_exp [$];
    int          q_acc [$];

    logic [89:0] m_act, m_pend;
    logic        m_pend_v;
    logic [17:0] m_x1, m_x2, m_y1, m_y2;

    always #5 clk = ~clk;

    module_iir_biquad_lpf dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .coefs_flat       (coefs_flat),
        .coefs_valid      (coefs_valid),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .dsp_ins_flat     (dsp_ins_flat),
        .dsp_outs_flat    (dsp_outs_flat)
    );

    // DSP model: two input pipeline stages, then the P accumulator (3 clocks issue-to-P).
    logic [91:0]        dsp_s1, dsp_s2;
    logic [47:0]        dsp_p;
    logic signed [47:0] dsp_prod;
    always_comb dsp_prod = $signed(dsp_s2[83:66]) * $signed(dsp_s2[65:48]);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsp_s1 <= '0;
            dsp_s2 <= '0;
            dsp_p  <= '0;
        end else begin
            dsp_s1 <= dsp_ins_flat;
            dsp_s2 <= dsp_s1;
            dsp_p  <= (((dsp_s2[91:84] & 8'h0C) == 8'h08) ? dsp_p : 48'd0) + dsp_prod;
        end
    end
    assign dsp_outs_flat = dsp_p;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [17:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [17:0] tb_coef(input logic [89:0] f, input int i);
        return f[(4-i)*18 +: 18];
    endfunction

    task automatic model_sample(input logic [17:0] x, output logic [17:0] y);
        longint      acc;
        logic [63:0] accb;
        acc = sx(tb_coef(m_act, 2)) * sx(x)    + sx(tb_coef(m_act, 3)) * sx(m_x1)
            + sx(tb_coef(m_act, 4)) * sx(m_x2) + sx(tb_coef(m_act, 0)) * sx(m_y1)
            + sx(tb_coef(m_act, 1)) * sx(m_y2);
        accb = acc;
        y = accb[33:16];
`ifdef IIR_BIQUAD_SATURATE_EN
        if (acc >= (longint'(1) <<< 33)) y = 18'h1FFFF;
        else if (acc < -(longint'(1) <<< 33)) y = 18'h20000;
`endif
        m_x2 = m_x1;
        m_x1 = x;
        m_y2 = m_y1;
        m_y1 = y;
    endtask

    always @(negedge clk) begin
        if (reset_n && sample_out_valid) begin
            n_out++;
            if (q_exp.size() == 0) begin
                check_val("spurious_out", 1, 0);
            end else begin
                logic [17:0] e;
                int          a;
                e = q_exp.pop_front();
                a = q_acc.pop_front();
                $display("OUT y=%05h exp=%05h latency=%0d", sample_out, e, cyc - a);
                check_val("sample_out", sample_out, e);
                check_val("latency", cyc - a, 9);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        coefs_valid = 1'b0;
        sample_in_valid = 1'b0;
        m_act = '0; m_pend = '0; m_pend_v = 1'b0;
        m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
        q_exp.delete();
        q_acc.delete();
        n_pushed = n_out;
        @(negedge clk);
        check_val("rst_sample_out", sample_out, 0);
        check_val("rst_out_valid", sample_out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_dsp_ins", dsp_ins_flat, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic load_coefs(input logic [17:0] c0, c1, c2, c3, c4);
        @(posedge clk);
        #1;
        coefs_flat  = {c0, c1, c2, c3, c4};
        coefs_valid = 1'b1;
        m_pend      = {c0, c1, c2, c3, c4};
        m_pend_v    = 1'b1;
        @(posedge clk);
        #1;
        coefs_valid = 1'b0;
    endtask

    task automatic drive_sample(input logic [17:0] x, input bit accept);
        logic [17:0] y;
        @(posedge clk);
        #1;
        sample_in       = x;
        sample_in_valid = 1'b1;
        if (accept) begin
            if (m_pend_v) begin
                m_act    = m_pend;
                m_pend_v = 1'b0;
            end
            model_sample(x, y);
            q_exp.push_back(y);
            q_acc.push_back(cyc + 1);
            n_pushed++;
        end
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
        if (accept) check_val("busy_after_accept", busy, 1);
    endtask

    task automatic wait_outputs();
        for (int k = 0; k < 40 && n_out < n_pushed; k++) @(negedge clk);
        if (n_out < n_pushed) check_val("out_timeout", n_out, n_pushed);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Passthrough
        load_coefs(18'h0, 18'h0, 18'h10000, 18'h0, 18'h0);
        drive_sample(18'h08000, 1);
        wait_outputs();

        // One-sample delay
        do_reset();
        load_coefs(18'h0, 18'h0, 18'h0, 18'h10000, 18'h0);
        drive_sample(18'h04000, 1);
        wait_outputs();
        drive_sample(18'h02000, 1);
        wait_outputs();

        // Feedback decay from an impulse
        do_reset();
        load_coefs(18'h08000, 18'h0, 18'h10000, 18'h0, 18'h0);
        drive_sample(18'h10000, 1);
        wait_outputs();
        drive_sample(18'h0, 1);
        wait_outputs();
        drive_sample(18'h0, 1);
        wait_outputs();

        // Coef update mid-MAC and a sample dropped while busy
        do_reset();
        load_coefs(18'h0, 18'h0, 18'h10000, 18'h0, 18'h0);
        drive_sample(18'h06000, 1);
        repeat (2) @(posedge clk);
        load_coefs(18'h0, 18'h0, 18'h08000, 18'h0, 18'h0);
        drive_sample(18'h01111, 0);
        wait_outputs();
        repeat (12) @(posedge clk);
        check_val("drop_no_extra", n_out, n_pushed);
        drive_sample(18'h06000, 1);
        wait_outputs();

        // Overflow: saturate or wrap depending on build
        do_reset();
        load_coefs(18'h0, 18'h0, 18'h1FFFF, 18'h0, 18'h0);
        drive_sample(18'h1FFFF, 1);
        wait_outputs();
        drive_sample(18'h3C000, 1);
        wait_outputs();

        // Reset mid-MAC, then a sample with cleared history
        do_reset();
        load_coefs(18'h08000, 18'h0, 18'h10000, 18'h10000, 18'h0);
        drive_sample(18'h04000, 1);
        wait_outputs();
        drive_sample(18'h02000, 1);
        repeat (2) @(posedge clk);
        do_reset();
        repeat (12) @(posedge clk);
        check_val("abort_no_out", n_out, n_pushed);
        load_coefs(18'h08000, 18'h0, 18'h10000, 18'h10000, 18'h0);
        drive_sample(18'h02000, 1);
        wait_outputs();
        repeat (4) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
